// File: rtl/prince_pkg.sv
// Shared constants for the PRINCE ShiftRows datapath: mode encoding,
// nibble index tables and the lane width.
package prince_pkg;

    localparam int LANE_W  = 64;
    localparam int NIBBLES = 16;

    localparam logic [1:0] MODE_ID  = 2'b00;
    localparam logic [1:0] MODE_FWD = 2'b01;
    localparam logic [1:0] MODE_INV = 2'b10;
    localparam logic [1:0] MODE_SR2 = 2'b11;

    typedef logic [3:0] nib_idx_t;

    // Output nibble i is taken from input nibble TABLE[i]; nibble 0 is the MSB nibble.
    localparam nib_idx_t FWD_T [NIBBLES] = '{
        4'd0, 4'd5, 4'd10, 4'd15, 4'd4, 4'd9, 4'd14, 4'd3,
        4'd8, 4'd13, 4'd2, 4'd7, 4'd12, 4'd1, 4'd6, 4'd11
    };
    localparam nib_idx_t INV_T [NIBBLES] = '{
        4'd0, 4'd13, 4'd10, 4'd7, 4'd4, 4'd1, 4'd14, 4'd11,
        4'd8, 4'd5, 4'd2, 4'd15, 4'd12, 4'd9, 4'd6, 4'd3
    };
    localparam nib_idx_t SR2_T [NIBBLES] = '{
        4'd0, 4'd9, 4'd2, 4'd11, 4'd4, 4'd13, 4'd6, 4'd15,
        4'd8, 4'd1, 4'd10, 4'd3, 4'd12, 4'd5, 4'd14, 4'd7
    };

    function automatic nib_idx_t sr_src(input logic [1:0] mode, input nib_idx_t idx);
        case (mode)
            MODE_FWD: sr_src = FWD_T[idx];
            MODE_INV: sr_src = INV_T[idx];
            MODE_SR2: sr_src = SR2_T[idx];
            default:  sr_src = idx;
        endcase
    endfunction

endpackage

// File: rtl/prince_sr_perm.sv
// Combinational ShiftRows nibble permutation for one 64-bit PRINCE state,
// selected by a 2-bit mode.
module prince_sr_perm
    import prince_pkg::*;
(
    input  logic [LANE_W-1:0] data_i,
    input  logic [1:0]        mode_i,
    output logic [LANE_W-1:0] data_o
);

    always_comb begin
        // NOTE: default the whole output first so the per-nibble loop can never leave a latch.
        data_o = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            data_o[LANE_W-1-4*i -: 4] =
                data_i[LANE_W-1-4*int'(sr_src(mode_i, nib_idx_t'(i))) -: 4];
        end
    end

endmodule

// File: rtl/prince_sr_stream.sv
// Streaming PRINCE ShiftRows unit: LANES states per beat, per-beat mode,
// STAGES-deep valid/ready pipeline with collapsing bubbles.
module prince_sr_stream
    import prince_pkg::*;
#(
    parameter int LANES  = 1,
    parameter int STAGES = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [1:0]                    in_mode,
    input  logic [LANE_W*LANES-1:0]       in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [1:0]                    out_mode,
    output logic [LANE_W*LANES-1:0]       out_data,
    output logic [$clog2(STAGES+1)-1:0]   occupancy
);

    localparam int W     = LANE_W * LANES;
    localparam int OCC_W = $clog2(STAGES + 1);

    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("prince_sr_stream: STAGES must be in 1..4");
    end
    if (LANES < 1 || LANES > 8) begin : g_bad_lanes
        $error("prince_sr_stream: LANES must be in 1..8");
    end

    logic [W-1:0]        perm_data;
    logic [STAGES:0]     ready;
    logic [STAGES-1:0]   v_q, v_d;
    logic [1:0]          mode_q [STAGES];
    logic [1:0]          mode_d [STAGES];
    logic [W-1:0]        data_q [STAGES];
    logic [W-1:0]        data_d [STAGES];
    logic [OCC_W-1:0]    occ_q, occ_d;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        prince_sr_perm u_perm (
            .data_i (in_data[l*LANE_W +: LANE_W]),
            .mode_i (in_mode),
            .data_o (perm_data[l*LANE_W +: LANE_W])
        );
    end

    // Stage k can load whenever any stage from k to the output has a hole, or the sink drains.
    assign ready[STAGES] = out_ready;
    for (genvar k = 0; k < STAGES; k++) begin : g_ready
        assign ready[k] = out_ready | ~(&v_q[STAGES-1:k]);
    end

    always_comb begin
        v_d    = v_q;
        mode_d = mode_q;
        data_d = data_q;
        if (ready[0]) begin
            v_d[0]    = in_valid;
            mode_d[0] = in_mode;
            data_d[0] = perm_data;
        end
        for (int k = 1; k < STAGES; k++) begin
            if (ready[k]) begin
                v_d[k]    = v_q[k-1];
                mode_d[k] = mode_q[k-1];
                data_d[k] = data_q[k-1];
            end
        end
        occ_d = '0;
        for (int k = 0; k < STAGES; k++) begin
            occ_d = occ_d + OCC_W'(v_d[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            occ_q <= '0;
            // NOTE: the stage payload registers are few and small, so they are cleared too; out_data reads 0 in reset.
            for (int k = 0; k < STAGES; k++) begin
                mode_q[k] <= '0;
                data_q[k] <= '0;
            end
        end else begin
            // NOTE: all state updates are non-blocking so every stage samples its upstream's pre-edge value.
            v_q    <= v_d;
            mode_q <= mode_d;
            data_q <= data_d;
            occ_q  <= occ_d;
        end
    end

    assign in_ready  = ready[0];
    assign out_valid = v_q[STAGES-1];
    assign out_mode  = mode_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
    assign occupancy = occ_q;

endmodule

// File: tb/tb_prince_sr_stream.sv
// Directed bench for prince_sr_stream across three configurations:
// (STAGES=1,LANES=1), (STAGES=3,LANES=1) and (STAGES=2,LANES=4).
module tb_prince_sr_stream;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Configuration A: STAGES=1, LANES=1
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [1:0]  a_in_mode, a_out_mode;
    logic [63:0] a_in_data, a_out_data;
    logic [0:0]  a_occ;

    // Configuration B: STAGES=3, LANES=1
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [1:0]  b_in_mode, b_out_mode;
    logic [63:0] b_in_data, b_out_data;
    logic [1:0]  b_occ;

    // Configuration C: STAGES=2, LANES=4
    logic         c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [1:0]   c_in_mode, c_out_mode;
    logic [255:0] c_in_data, c_out_data;
    logic [1:0]   c_occ;

    prince_sr_stream #(.LANES(1), .STAGES(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mode(a_in_mode), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_mode(a_out_mode), .out_data(a_out_data),
        .occupancy(a_occ)
    );

    prince_sr_stream #(.LANES(1), .STAGES(3)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_mode(b_out_mode), .out_data(b_out_data),
        .occupancy(b_occ)
    );

    prince_sr_stream #(.LANES(4), .STAGES(2)) dut_c (
        .clk(clk), .rst_n(rst_n),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_mode(c_in_mode), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_mode(c_out_mode), .out_data(c_out_data),
        .occupancy(c_occ)
    );

    // Reference: the four tables are i*{1,5,13,9} mod 16.
    function automatic logic [63:0] ref_sr(input logic [63:0] d, input logic [1:0] m);
        int mult;
        logic [63:0] r;
        case (m)
            2'd1:    mult = 5;
            2'd2:    mult = 13;
            2'd3:    mult = 9;
            default: mult = 1;
        endcase
        r = '0;
        for (int i = 0; i < 16; i++) begin
            int src;
            src = (mult * i) % 16;
            r[63-4*i -: 4] = d[63-4*src -: 4];
        end
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        a_in_valid = 0; a_in_mode = 0; a_in_data = '0; a_out_ready = 1;
        b_in_valid = 0; b_in_mode = 0; b_in_data = '0; b_out_ready = 1;
        c_in_valid = 0; c_in_mode = 0; c_in_data = '0; c_out_ready = 1;
        #22;
        n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL rst_a_in_ready: got %b want 1", a_in_ready); end
        n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_a_out_valid: got %b want 0", a_out_valid); end
        n_cmp++; if (a_occ !== 1'b0) begin n_err++; $display("FAIL rst_a_occ: got %0d want 0", a_occ); end
        n_cmp++; if (b_out_data !== 64'h0) begin n_err++; $display("FAIL rst_b_out_data: got %h want 0", b_out_data); end
        n_cmp++; if (b_occ !== 2'd0) begin n_err++; $display("FAIL rst_b_occ: got %0d want 0", b_occ); end
        n_cmp++; if (c_in_ready !== 1'b1 || c_out_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_c_hs: got ready=%b valid=%b want 1/0", c_in_ready, c_out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_modes();
        logic [63:0] exp_v [4];
        exp_v[0] = 64'h0123456789ABCDEF;
        exp_v[1] = 64'h05AF49E38D27C16B;
        exp_v[2] = 64'h0DA741EB852FC963;
        exp_v[3] = 64'h092B4D6F81A3C5E7;
        for (int m = 0; m < 4; m++) begin
            @(negedge clk);
            n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL mode%0d_idle: out_valid got %b want 0", m, a_out_valid); end
            a_in_valid = 1; a_in_mode = 2'(m); a_in_data = 64'h0123456789ABCDEF;
            @(negedge clk);
            a_in_valid = 0;
            n_cmp++; if (a_out_valid !== 1'b1) begin n_err++; $display("FAIL mode%0d_valid: got %b want 1", m, a_out_valid); end
            n_cmp++; if (a_out_data !== exp_v[m]) begin n_err++; $display("FAIL mode%0d_data: got %h want %h", m, a_out_data, exp_v[m]); end
            n_cmp++; if (a_out_mode !== 2'(m)) begin n_err++; $display("FAIL mode%0d_mode: got %0d want %0d", m, a_out_mode, m); end
        end
    endtask

    task automatic test_chain();
        logic [1:0]  md  [2];
        logic [63:0] exp_v [2];
        md[0] = 2'd2; exp_v[0] = 64'h0123456789ABCDEF;
        md[1] = 2'd1; exp_v[1] = 64'h092B4D6F81A3C5E7;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            a_in_valid = 1; a_in_mode = md[i]; a_in_data = 64'h05AF49E38D27C16B;
            @(negedge clk);
            a_in_valid = 0;
            n_cmp++; if (a_out_valid !== 1'b1 || a_out_data !== exp_v[i]) begin
                n_err++; $display("FAIL chain%0d: got v=%b %h want v=1 %h", i, a_out_valid, a_out_data, exp_v[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] dat [100];
        logic [1:0]  md  [100];
        for (int i = 0; i < 100; i++) begin
            dat[i] = {$urandom, $urandom};
            md[i]  = 2'($urandom_range(0, 3));
        end
        b_out_ready = 1;
        for (int c = 0; c <= 102; c++) begin
            @(negedge clk);
            if (c >= 3) begin
                n_cmp++; if (b_out_valid !== 1'b1 || b_out_data !== ref_sr(dat[c-3], md[c-3]) || b_out_mode !== md[c-3]) begin
                    n_err++; $display("FAIL b2b_beat%0d: got v=%b %h m=%0d want v=1 %h m=%0d",
                                      c-3, b_out_valid, b_out_data, b_out_mode, ref_sr(dat[c-3], md[c-3]), md[c-3]);
                end
            end
            if (c >= 3 && c <= 100) begin
                n_cmp++; if (b_occ !== 2'd3) begin n_err++; $display("FAIL b2b_occ@%0d: got %0d want 3", c, b_occ); end
            end
            n_cmp++; if (b_in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready@%0d: got %b want 1", c, b_in_ready); end
            if (c < 100) begin
                b_in_valid = 1; b_in_data = dat[c]; b_in_mode = md[c];
            end else begin
                b_in_valid = 0;
            end
        end
        @(negedge clk);
        n_cmp++; if (b_out_valid !== 1'b0 || b_occ !== 2'd0) begin
            n_err++; $display("FAIL b2b_drain: got v=%b occ=%0d want 0/0", b_out_valid, b_occ);
        end
    endtask

    task automatic test_stall();
        logic [63:0] sd [4];
        logic [1:0]  sm [4];
        int n;
        sd[0] = 64'h0123456789ABCDEF; sm[0] = 2'd1;
        sd[1] = 64'hFEDCBA9876543210; sm[1] = 2'd2;
        sd[2] = 64'h0F1E2D3C4B5A6978; sm[2] = 2'd3;
        sd[3] = 64'hA5A55A5AC3C33C3C; sm[3] = 2'd0;
        n = 0;
        b_out_ready = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (!b_in_ready) break;
            if (n < 3) begin
                b_in_valid = 1; b_in_data = sd[n]; b_in_mode = sm[n];
            end else begin
                b_in_valid = 1; b_in_data = sd[3]; b_in_mode = sm[3];
            end
            n++;
        end
        n_cmp++; if (n !== 3) begin n_err++; $display("FAIL stall_accepts: got %0d want 3", n); end
        n_cmp++; if (b_occ !== 2'd3) begin n_err++; $display("FAIL stall_occ: got %0d want 3", b_occ); end
        b_in_valid = 1; b_in_data = sd[3]; b_in_mode = sm[3];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (b_in_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready%0d: got %b want 0", i, b_in_ready); end
            n_cmp++; if (b_out_valid !== 1'b1 || b_out_data !== 64'h05AF49E38D27C16B || b_out_mode !== 2'd1) begin
                n_err++; $display("FAIL stall_hold%0d: got v=%b %h m=%0d want v=1 05af49e38d27c16b m=1",
                                  i, b_out_valid, b_out_data, b_out_mode);
            end
        end
        b_out_ready = 1;
        #1;
        n_cmp++; if (b_in_ready !== 1'b1) begin n_err++; $display("FAIL stall_ready_follow: got %b want 1", b_in_ready); end
        @(negedge clk);
        b_out_ready = 0; b_in_valid = 0;
        n_cmp++; if (b_occ !== 2'd3) begin n_err++; $display("FAIL stall_swap_occ: got %0d want 3", b_occ); end
        n_cmp++; if (b_out_data !== ref_sr(sd[1], sm[1])) begin
            n_err++; $display("FAIL stall_swap_data: got %h want %h", b_out_data, ref_sr(sd[1], sm[1]));
        end
        @(negedge clk);
        n_cmp++; if (b_out_data !== ref_sr(sd[1], sm[1]) || b_out_mode !== sm[1]) begin
            n_err++; $display("FAIL stall_hold_b1: got %h m=%0d want %h m=%0d", b_out_data, b_out_mode, ref_sr(sd[1], sm[1]), sm[1]);
        end
        b_out_ready = 1;
        for (int i = 2; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (b_out_valid !== 1'b1 || b_out_data !== ref_sr(sd[i], sm[i])) begin
                n_err++; $display("FAIL stall_drain%0d: got v=%b %h want v=1 %h", i, b_out_valid, b_out_data, ref_sr(sd[i], sm[i]));
            end
        end
        @(negedge clk);
        n_cmp++; if (b_out_valid !== 1'b0 || b_occ !== 2'd0) begin
            n_err++; $display("FAIL stall_empty: got v=%b occ=%0d want 0/0", b_out_valid, b_occ);
        end
    endtask

    task automatic test_lanes();
        logic [255:0] exp_d;
        exp_d = {64'hFFFFFFFFFFFFFFFF, 64'h0, 64'hFA50B61C72D83E94, 64'h05AF49E38D27C16B};
        c_out_ready = 1;
        @(negedge clk);
        c_in_valid = 1; c_in_mode = 2'd1;
        c_in_data  = {64'hFFFFFFFFFFFFFFFF, 64'h0, ~64'h0123456789ABCDEF, 64'h0123456789ABCDEF};
        @(negedge clk);
        c_in_valid = 0;
        n_cmp++; if (c_out_valid !== 1'b0) begin n_err++; $display("FAIL lanes_early: got %b want 0", c_out_valid); end
        @(negedge clk);
        n_cmp++; if (c_out_valid !== 1'b1 || c_out_mode !== 2'd1) begin
            n_err++; $display("FAIL lanes_hs: got v=%b m=%0d want 1/1", c_out_valid, c_out_mode);
        end
        for (int l = 0; l < 4; l++) begin
            n_cmp++; if (c_out_data[l*64 +: 64] !== exp_d[l*64 +: 64]) begin
                n_err++; $display("FAIL lane%0d: got %h want %h", l, c_out_data[l*64 +: 64], exp_d[l*64 +: 64]);
            end
        end
    endtask

    task automatic test_midreset();
        b_out_ready = 1;
        @(negedge clk);
        b_in_valid = 1; b_in_mode = 2'd1; b_in_data = 64'h1122334455667788;
        @(negedge clk);
        b_in_valid = 1; b_in_mode = 2'd2; b_in_data = 64'h99AABBCCDDEEFF00;
        @(negedge clk);
        b_in_valid = 0;
        @(negedge clk);
        n_cmp++; if (b_out_valid !== 1'b1 || b_occ !== 2'd2) begin
            n_err++; $display("FAIL mid_inflight: got v=%b occ=%0d want 1/2", b_out_valid, b_occ);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (b_out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", b_out_valid); end
        n_cmp++; if (b_occ !== 2'd0) begin n_err++; $display("FAIL mid_occ: got %0d want 0", b_occ); end
        n_cmp++; if (b_out_data !== 64'h0) begin n_err++; $display("FAIL mid_data: got %h want 0", b_out_data); end
        n_cmp++; if (b_in_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready: got %b want 1", b_in_ready); end
        #1 rst_n = 1'b1;
        @(negedge clk);
        b_in_valid = 1; b_in_mode = 2'd2; b_in_data = 64'h0123456789ABCDEF;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            b_in_valid = 0;
            if (c == 3) begin
                n_cmp++; if (b_out_valid !== 1'b1 || b_out_data !== 64'h0DA741EB852FC963 || b_out_mode !== 2'd2) begin
                    n_err++; $display("FAIL mid_after: got v=%b %h m=%0d want v=1 0da741eb852fc963 m=2", b_out_valid, b_out_data, b_out_mode);
                end
            end else begin
                n_cmp++; if (b_out_valid !== 1'b0) begin n_err++; $display("FAIL mid_stale@%0d: got %b want 0", c, b_out_valid); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_chain();
        test_back_to_back();
        test_stall();
        test_lanes();
        test_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
